acc_exec_sequencer: RTL and testbench

//   Execute-stage sequencer that sits directly upstream of the ALU. It owns the 8-bit

---
 rtl/acc_exec_sequencer.sv | 99 +++++++++
 tb/tb_acc_exec_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_exec_sequencer.sv
// Execute-stage sequencer: owns the accumulator, feeds the ALU operands and writes
// the ALU result back, optionally repeating one opcode a fixed number of extra times.
module acc_exec_sequencer #(
    parameter int WIDTH = 8,
    parameter int OPW   = 4,
    parameter int CNTW  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [OPW-1:0]   req_opcode,
    input  logic [WIDTH-1:0] req_operand,
    input  logic [CNTW-1:0]  req_count,
    input  logic             flush,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_opcode,
    input  logic [WIDTH-1:0] alu_y,
    output logic [WIDTH-1:0] acc,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    localparam logic [OPW-1:0] OP_LOAD = '1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] operand_q, operand_d;
    logic [OPW-1:0]   opcode_q, opcode_d;
    logic [CNTW-1:0]  remain_q, remain_d;
    logic             zero_q, zero_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            operand_q <= '0;
            opcode_q  <= '0;
            remain_q  <= '0;
            zero_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            operand_q <= operand_d;
            opcode_q  <= opcode_d;
            remain_q  <= remain_d;
            zero_q    <= zero_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        operand_d = operand_q;
        opcode_d  = opcode_q;
        remain_d  = remain_q;
        case (state_q)
            IDLE: begin
                if (req_valid && !flush) begin
                    opcode_d  = req_opcode;
                    operand_d = req_operand;
                    remain_d  = req_count;
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                // An abort leaves acc at the last fully completed iteration.
                if (flush) begin
                    state_d = IDLE;
                end else if (opcode_q == OP_LOAD) begin
                    acc_d   = operand_q;
                    state_d = DONE;
                end else begin
                    acc_d = alu_y;
                    if (remain_q == '0) state_d = DONE;
                    else                remain_d = remain_q - CNTW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // acc_d equals acc_q when nothing is written, so this tracks every write.
        zero_d = (acc_d == '0);
    end

    assign req_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign alu_a      = acc_q;
    assign alu_b      = operand_q;
    assign alu_opcode = opcode_q;
    assign acc        = acc_q;
    assign zero       = zero_q;

endmodule

// File: tb/tb_acc_exec_sequencer.sv
// Bench for acc_exec_sequencer: directed + random requests, a behavioural ALU and an
// expected-result queue drained by an independent monitor.
module tb_acc_exec_sequencer;

    localparam int N = 60;
    localparam logic [3:0] OP_LOAD = 4'hF;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_opcode;
    logic [7:0] req_operand;
    logic [2:0] req_count;
    logic       flush;
    logic [7:0] alu_a, alu_b, alu_y, acc;
    logic [3:0] alu_opcode;
    logic       zero, busy, done;

    acc_exec_sequencer #(.WIDTH(8), .OPW(4), .CNTW(3)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_opcode(req_opcode), .req_operand(req_operand), .req_count(req_count),
        .flush(flush), .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_y(alu_y), .acc(acc), .zero(zero), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Simple external ALU: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL1, 6 SHR1, else pass B.
    function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return a << 1;
            4'd6: return a >> 1;
            default: return b;
        endcase
    endfunction

    always_comb alu_y = alu_f(alu_opcode, alu_a, alu_b);

    // mode: 0 normal, 1 flush in EXEC cycle k, 2 flush during DONE, 3 reset in EXEC cycle k
    typedef struct {
        logic [3:0] op;
        logic [7:0] b;
        logic [2:0] cnt;
        int         mode;
        int         k;
        bit         b2b;
    } req_t;

    typedef struct {
        bit         exp_done;
        logic [7:0] acc;
        int         done_cyc;
    } sb_t;

    req_t reqs[N];
    sb_t  sb_q[$];
    sb_t  mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;
    logic prev_busy = 1'b0;
    logic prev_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: one scoreboard entry per completed or aborted operation.
    always @(negedge clk) begin
        if (mon_en) begin
            if (done === 1'b1) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL done_unexpected: done high at cycle %0d with empty scoreboard", cyc);
                end else begin
                    mon_e = sb_q.pop_front();
                    if (!mon_e.exp_done || acc !== mon_e.acc || zero !== (mon_e.acc == 8'h00) ||
                        cyc != mon_e.done_cyc || prev_done !== 1'b0) begin
                        errors++;
                        $display("FAIL op_done: got acc=%h zero=%b cyc=%0d prev_done=%b, want exp_done=%0d acc=%h zero=%b cyc=%0d prev_done=0",
                                 acc, zero, cyc, prev_done, mon_e.exp_done, mon_e.acc, mon_e.acc == 8'h00, mon_e.done_cyc);
                    end
                end
            end else if (busy === 1'b0 && prev_busy === 1'b1 && prev_done !== 1'b1) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL abort_unexpected: op ended without done at cycle %0d, scoreboard empty", cyc);
                end else begin
                    mon_e = sb_q.pop_front();
                    if (mon_e.exp_done || acc !== mon_e.acc || zero !== (mon_e.acc == 8'h00)) begin
                        errors++;
                        $display("FAIL op_abort: got acc=%h zero=%b no-done, want exp_done=%0d acc=%h zero=%b",
                                 acc, zero, mon_e.exp_done, mon_e.acc, mon_e.acc == 8'h00);
                    end
                end
            end
            prev_busy <= busy;
            prev_done <= done;
        end
    end

    task automatic set_fields(input req_t r);
        req_opcode  = r.op;
        req_operand = r.b;
        req_count   = r.cnt;
    endtask

    task automatic gen_reqs();
        req_t r;
        logic [3:0] ops[8];
        ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, OP_LOAD};
        reqs[0]  = '{OP_LOAD, 8'h05, 3'd0, 0, 0, 1'b0};
        reqs[1]  = '{4'd0,    8'h03, 3'd0, 0, 0, 1'b0};
        reqs[2]  = '{OP_LOAD, 8'hFE, 3'd0, 0, 0, 1'b0};
        reqs[3]  = '{4'd0,    8'h01, 3'd3, 0, 0, 1'b0};
        reqs[4]  = '{OP_LOAD, 8'h01, 3'd0, 0, 0, 1'b0};
        reqs[5]  = '{4'd5,    8'h00, 3'd5, 1, 3, 1'b0};
        reqs[6]  = '{OP_LOAD, 8'h10, 3'd0, 0, 0, 1'b0};
        reqs[7]  = '{4'd0,    8'h01, 3'd2, 0, 0, 1'b0};
        reqs[8]  = '{4'd1,    8'h13, 3'd0, 0, 0, 1'b1};
        reqs[9]  = '{4'd0,    8'h05, 3'd7, 3, 4, 1'b1};
        reqs[10] = '{4'd4,    8'h5A, 3'd1, 2, 0, 1'b0};
        for (int i = 11; i < N; i++) begin
            int n;
            r.op  = ops[$urandom_range(0, 7)];
            r.b   = 8'($urandom);
            r.cnt = 3'($urandom);
            n     = (r.op == OP_LOAD) ? 0 : int'(r.cnt);
            r.mode = ($urandom_range(0, 9) < 6) ? 0 : int'($urandom_range(1, 3));
            r.k    = int'($urandom_range(1, n + 1));
            r.b2b  = $urandom_range(0, 1) == 1;
            reqs[i] = r;
        end
    endtask

    initial begin
        logic [7:0] model_acc;
        logic [7:0] res;
        int  c0, prev_c0, prev_n, prev_mode, n, iters, t;
        bit  aborted;
        sb_t e;

        gen_reqs();
        rst = 1'b1; req_valid = 1'b0; flush = 1'b0;
        req_opcode = '0; req_operand = '0; req_count = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks += 5;
        if (acc !== 8'h00)     begin errors++; $display("FAIL reset_acc: got %h want 00", acc); end
        if (zero !== 1'b1)     begin errors++; $display("FAIL reset_zero: got %b want 1", zero); end
        if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", req_ready); end
        if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (done !== 1'b0)     begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        mon_en = 1'b1;

        // A request presented together with flush in IDLE must not be taken.
        req_valid = 1'b1; flush = 1'b1; req_opcode = OP_LOAD; req_operand = 8'hAA;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || acc !== 8'h00) begin
            errors++;
            $display("FAIL idle_flush: got busy=%b acc=%h want busy=0 acc=00", busy, acc);
        end
        req_valid = 1'b0; flush = 1'b0;

        model_acc = 8'h00; prev_c0 = 0; prev_n = 0; prev_mode = 1; aborted = 1'b0;
        for (int i = 0; i < N && !aborted; i++) begin
            if (i == 0 || !reqs[i].b2b) set_fields(reqs[i]);
            req_valid = 1'b1;
            t = 0;
            while (!(req_ready === 1'b1 && !flush) && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (t >= 50) begin
                checks++; errors++;
                $display("FAIL accept_timeout: req %0d not accepted within 50 cycles", i);
                aborted = 1'b1;
                break;
            end
            @(posedge clk);
            #1 c0 = cyc;

            n = (reqs[i].op == OP_LOAD) ? 0 : int'(reqs[i].cnt);
            iters = (reqs[i].mode == 1 || reqs[i].mode == 3) ? reqs[i].k - 1 : n + 1;
            res = model_acc;
            for (int j = 0; j < iters; j++)
                res = (reqs[i].op == OP_LOAD) ? reqs[i].b : alu_f(reqs[i].op, res, reqs[i].b);
            if (reqs[i].mode == 3) res = 8'h00;
            e.exp_done = (reqs[i].mode == 0 || reqs[i].mode == 2);
            e.acc      = res;
            e.done_cyc = c0 + n + 1;
            sb_q.push_back(e);
            model_acc = res;

            if (reqs[i].b2b && i > 0 && prev_mode == 0) begin
                checks++;
                if (c0 != prev_c0 + prev_n + 3) begin
                    errors++;
                    $display("FAIL b2b_accept: req %0d accepted at cycle %0d, want %0d", i, c0, prev_c0 + prev_n + 3);
                end
            end

            if (i + 1 < N && reqs[i + 1].b2b) set_fields(reqs[i + 1]);
            else req_valid = 1'b0;

            case (reqs[i].mode)
                1: begin
                    repeat (reqs[i].k - 1) @(posedge clk);
                    #1 flush = 1'b1;
                    @(posedge clk);
                    #1 flush = 1'b0;
                end
                2: begin
                    repeat (n + 1) @(posedge clk);
                    #1 flush = 1'b1;
                    @(posedge clk);
                    #1 flush = 1'b0;
                end
                3: begin
                    repeat (reqs[i].k - 1) @(posedge clk);
                    #1 rst = 1'b1;
                    @(posedge clk);
                    #1 rst = 1'b0;
                end
                default: ;
            endcase

            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (busy !== 1'b0 && t < 40);
            if (t >= 40) begin
                checks++; errors++;
                $display("FAIL op_timeout: req %0d still busy after 40 cycles", i);
                aborted = 1'b1;
            end
            prev_c0 = c0; prev_n = n; prev_mode = reqs[i].mode;
        end

        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
